// File: rtl/reg_bus_arbiter.sv
// Two-port register bus arbiter: a core (A) and a host/debug (B) requester share one
// register bus with round-robin grant and a single outstanding read.
module reg_bus_arbiter #(
  parameter int INDEX_WIDTH = 7,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_write,
  input  logic [INDEX_WIDTH-1:0] a_index,
  input  logic [DATA_WIDTH-1:0]  a_wdata,
  output logic                   a_ready,
  output logic                   a_rsp_valid,
  output logic [DATA_WIDTH-1:0]  a_rsp_data,
  input  logic                   b_valid,
  input  logic                   b_write,
  input  logic [INDEX_WIDTH-1:0] b_index,
  input  logic [DATA_WIDTH-1:0]  b_wdata,
  output logic                   b_ready,
  output logic                   b_rsp_valid,
  output logic [DATA_WIDTH-1:0]  b_rsp_data,
  output logic [INDEX_WIDTH-1:0] register_index,
  output logic                   register_read,
  output logic                   register_write,
  output logic [DATA_WIDTH-1:0]  register_write_value,
  input  logic [DATA_WIDTH-1:0]  register_read_value
);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t                state, state_next;
  logic                  last_grant;  // 0 = A, 1 = B
  logic                  owner;
  logic [DATA_WIDTH-1:0] a_rsp_hold, b_rsp_hold;
  logic                  issue, issue_read, grant_b;

  always_comb begin
    state_next           = state;
    a_ready              = 1'b0;
    b_ready              = 1'b0;
    a_rsp_valid          = 1'b0;
    b_rsp_valid          = 1'b0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_index       = '0;
    register_write_value = '0;
    issue                = 1'b0;
    issue_read           = 1'b0;
    grant_b              = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (a_valid || b_valid) begin
            issue   = 1'b1;
            // B wins only when alone or when A was served most recently.
            grant_b = b_valid && (!a_valid || !last_grant);
            if (grant_b) begin
              b_ready              = 1'b1;
              register_index       = b_index;
              register_write       = b_write;
              register_read        = !b_write;
              register_write_value = b_write ? b_wdata : '0;
            end else begin
              a_ready              = 1'b1;
              register_index       = a_index;
              register_write       = a_write;
              register_read        = !a_write;
              register_write_value = a_write ? a_wdata : '0;
            end
            issue_read = register_read;
            if (issue_read) state_next = READ_WAIT;
          end
        end
        READ_WAIT: begin
          a_rsp_valid = !owner;
          b_rsp_valid = owner;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign a_rsp_data = a_rsp_valid ? register_read_value : a_rsp_hold;
  assign b_rsp_data = b_rsp_valid ? register_read_value : b_rsp_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_rsp_hold <= '0;
      b_rsp_hold <= '0;
    end else begin
      state <= state_next;
      if (issue)       last_grant <= grant_b;
      if (issue_read)  owner      <= grant_b;
      if (a_rsp_valid) a_rsp_hold <= register_read_value;
      if (b_rsp_valid) b_rsp_hold <= register_read_value;
    end
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter INDEX_WIDTH, default 7: width of the hardware register index.
REQ-002 Parameter DATA_WIDTH, default 16: width of register read/write data.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid / a_write  input  1 / 1  port A (core) request present / request is a write.
REQ-006 a_index / a_wdata  input  INDEX_WIDTH / DATA_WIDTH  port A register index / write data.
REQ-007 a_ready  output  1  port A request accepted this cycle.
REQ-008 a_rsp_valid / a_rsp_data  output  1 / DATA_WIDTH  port A read response strobe / data.
REQ-009 b_valid, b_write, b_index, b_wdata, b_ready, b_rsp_valid, b_rsp_data: same widths and meanings for port B (host/debug).
REQ-010 register_index  output  INDEX_WIDTH  index of the access issued this cycle.
REQ-011 register_read / register_write  output  1 / 1  read / write strobe; at most one high per cycle.
REQ-012 register_write_value  output  DATA_WIDTH  write data of the issued access.
REQ-013 register_read_value  input  DATA_WIDTH  peripheral read data, valid the cycle after register_read.

Function
REQ-014 FSM states: IDLE (may issue), READ_WAIT (read outstanding, no issue).
REQ-015 In IDLE with at least one valid request, exactly one request is issued that cycle: strobe, index, write value driven combinationally from the granted port; granted port's ready high that cycle only.
REQ-016 Only one valid: that port is granted. Both valid: the port not granted most recently wins (round-robin; last_grant is a 1-bit register, reset to B so A wins first contention).
REQ-017 last_grant updates on every issue, reads and writes alike.
REQ-018 Issued write: register_write high one cycle; FSM stays IDLE; next access may issue the following cycle; no response strobe for writes.
REQ-019 Issued read: register_read high one cycle; FSM -> READ_WAIT; owner recorded in a 1-bit register.
REQ-020 READ_WAIT: register_read_value captured; owner's rsp_valid high exactly this cycle with rsp_data = register_read_value (combinational pass-through); both ready low; all strobes low; FSM -> IDLE.
REQ-021 Read latency: request accepted cycle N -> rsp_valid cycle N+1; one port's back-to-back reads issue at N, N+2, N+4.
REQ-022 Requesters hold valid/write/index/wdata stable until ready; a request withdrawn before ready causes no bus access.
REQ-023 When no access is issued, register_read = register_write = 0, register_index = 0, register_write_value = 0.
REQ-024 rsp_data holds its last delivered value when rsp_valid is low; only value at rsp_valid is defined.
REQ-025 Non-owner port's rsp_valid stays 0 in READ_WAIT; its pending request waits and is granted in the next IDLE cycle.

Reset
REQ-026 Reset asserted at any clock edge forces FSM = IDLE, last_grant = B, owner = A, a_rsp_data = b_rsp_data = 0.
REQ-027 While reset is high: all ready, rsp_valid, register_read and register_write are 0; no access issued.
REQ-028 Reset during READ_WAIT discards the outstanding read; no rsp_valid is produced for it after reset.
REQ-029 First cycle after reset deasserts is IDLE and may issue.

Verification
REQ-030 A only: A write idx 0x05 data 0x1234 -> same cycle register_write=1, index 0x05, value 0x1234, a_ready=1; next cycle bus idle.
REQ-031 A read idx 0x7F, peripheral returns 0xBEEF next cycle -> register_read=1 cycle N, a_rsp_valid=1 with 0xBEEF cycle N+1, b_rsp_valid=0.
REQ-032 A and B both valid with reads after reset -> A issued N, B issued N+2, A again N+4 if still valid; never two strobes same cycle.
REQ-033 B write while A read outstanding -> B waits through READ_WAIT; b_ready and register_write high at N+2.
REQ-034 Reset high in READ_WAIT cycle -> no rsp_valid then or after; first post-reset contention granted to A.
REQ-035 A valid withdrawn while B holds bus in READ_WAIT -> no access for A; only B's response appears.
